mylstar_rom_loader: RTL and testbench
=====================================

// Module: mylstar_rom_loader
// PURPOSE
// Sits between hps_io's ioctl download stream and mylstar_board/ma216_board ROM init ports.
// Decodes ROM download byte addresses into four ROM regions: CPU, sound, background, sprite.
// Packs sprite bytes into 16-bit words and back-pressures hps_io through ioctl_wait.
// Captures the game-select byte. Produces rom_loaded, which gates board reset.
// PARAMETERS
// SND_BASE  25'h10000  first byte of sound ROM region (8K)
// BG_BASE   25'h12000  first byte of background tile region (32K)
// SPR_BASE  25'h1A000  first byte of sprite region (64K bytes = 32K words)
// END_ADDR  25'h2A000  first byte past sprite region; addresses >= this are out of range
// PORTS
// clk_sys         in   1   system clock; all logic on rising edge
// reset           in   1   synchronous, active-high
// ioctl_download  in   1   download active (clk_sys domain)
// ioctl_index     in   8   0 = ROM image, 1 = game-select byte
// ioctl_wr        in   1   one-cycle byte strobe
// ioctl_addr      in   25  byte address
// ioctl_dout      in   8   byte data
// ioctl_wait      out  1   high = hps_io must hold the next byte
// rom_we          out  1   output slot valid; held until accepted
// rom_region      out  2   0 CPU, 1 sound, 2 background, 3 sprite
// rom_addr        out  16  byte address in region (sprite: word address, bit 15 = 0)
// rom_data        out  16  [7:0] byte / even sprite byte; [15:8] odd sprite byte
// rom_be          out  2   byte enables (2'b01 for non-sprite regions)
// rom_ready       in   1   sink accepts the slot on a cycle where rom_we & rom_ready
// rom_loaded      out  1   ROM image fully written
// mod             out  8   game-select byte
// checksum        out  16  mod-2^16 sum of all ROM-index bytes received
// overflow        out  1   sticky; a ROM byte at >= END_ADDR was received
// BEHAVIOUR
// Reset values: rom_we=0, ioctl_wait=0, rom_loaded=0, mod=8'hFF, checksum=0, overflow=0.
// Reset also clears the pending sprite byte and sets FSM to IDLE.
// Reset mid-download abandons the load. rom_loaded stays 0 until a later complete download.
// FSM states:
// - IDLE: -> LOAD when ioctl_download & index==0.
//   On entry to LOAD: rom_loaded<=0, checksum<=0, overflow<=0, pending cleared.
// - LOAD: -> DRAIN when ioctl_download falls.
// - DRAIN: flushes the pending sprite byte (be=01) and the output slot; -> DONE when both are empty.
// - DONE: rom_loaded<=1. -> LOAD on a new index-0 download.
// Index 1: any ioctl_wr in any state does mod<=ioctl_dout. Last byte wins. No ROM write.
// Output slot: one deep.
// - Non-sprite byte at cycle N: rom_we=1 at N+1, with address = ioctl_addr minus region base.
// - Sprite even byte: latched as pending; no write.
// - Sprite odd byte: write at N+1, rom_addr = offset>>1.
//   be=11 if pending holds the same word, else be=10. Pending is then cleared.
// - Sprite even byte while pending is set: flush old pending (be=01) first; new byte becomes pending.
// Output slot hold: rom_we/addr/data/be stay stable until rom_we&rom_ready. The slot frees in that cycle.
// ioctl_wait = slot occupied & ~(rom_we&rom_ready), or a pending flush is queued.
// - Combinational from registers.
// - A byte arriving while ioctl_wait=1 is a protocol violation. It is dropped.
// Out-of-range byte: no write, overflow<=1, still added to checksum.
// checksum adds every index-0 byte in LOAD, including out-of-range bytes. Wraps mod 2^16.
// Writes with ioctl_download=0 are ignored.
// TESTING
// 1 Reset, then sequential index-0 bytes 0x00..0x0F at addr 0..15 with rom_ready=1:
//   rom_we at N+1, region 0, addr 0..15, be=01; checksum=0x0078 after download falls.
//   rom_loaded=1 within 2 cycles.
// 2 Bytes 0xAA@0x1A000 then 0x55@0x1A001:
//   one write, region 3, addr 0, data 0x55AA, be=11.
// 3 Odd-length sprite load ending with 0x77@0x1A004; download falls:
//   DRAIN writes addr 2, data 0x0077, be=01; rom_loaded rises only after acceptance.
// 4 rom_ready=0 for 5 cycles with slot full:
//   ioctl_wait=1 throughout, outputs stable; single write when ready returns; wait drops the same cycle.
// 5 Byte at 0x2A000 -> overflow=1, no rom_we. Index-1 byte 0x04 -> mod=0x04, rom_loaded unchanged.
// 6 Reset asserted mid-LOAD with slot full:
//   next cycle rom_we=0, ioctl_wait=0, rom_loaded=0; new download completes normally.

Source files
------------

// File: rtl/mylstar_rom_loader_if.sv
// Bundles the hps_io ioctl download stream and the board ROM init port.
// The loader is the slave; the environment (hps_io + board sink) is the master.
interface mylstar_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_we;
  logic [1:0]  rom_region;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [1:0]  rom_be;
  logic        rom_ready;
  logic        rom_loaded;
  logic [7:0]  mod;
  logic [15:0] checksum;
  logic        overflow;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
    input  ioctl_wait, rom_we, rom_region, rom_addr, rom_data, rom_be,
           rom_loaded, mod, checksum, overflow
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
    output ioctl_wait, rom_we, rom_region, rom_addr, rom_data, rom_be,
           rom_loaded, mod, checksum, overflow
  );
endinterface

// File: rtl/mylstar_rom_loader.sv
// Routes hps_io ROM download bytes into CPU/sound/background/sprite init writes,
// pairing sprite bytes into 16-bit words and stalling hps_io while the output slot is busy.
module mylstar_rom_loader #(
  parameter logic [24:0] SND_BASE = 25'h10000,
  parameter logic [24:0] BG_BASE  = 25'h12000,
  parameter logic [24:0] SPR_BASE = 25'h1A000,
  parameter logic [24:0] END_ADDR = 25'h2A000
) (
  input logic clk_sys,
  input logic reset,
  mylstar_rom_loader_if.slave io
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [1:0]  region;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } slot_t;

  state_t      state, state_nxt;
  slot_t       slot, slot_nxt, pend_slot;
  logic        slot_vld, slot_vld_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [14:0] pend_word, pend_word_nxt;
  logic [7:0]  pend_data, pend_data_nxt;
  logic        flush_q, flush_q_nxt;
  logic [15:0] checksum, checksum_nxt;
  logic        overflow, overflow_nxt;
  logic        loaded, loaded_nxt;
  logic [7:0]  mod;

  logic        accept, slot_free, wr_ok, start, in_range;
  logic [1:0]  region;
  logic [15:0] off;

  assign accept        = slot_vld & io.rom_ready;
  assign slot_free     = ~slot_vld | accept;
  assign io.ioctl_wait = (slot_vld & ~accept) | flush_q;
  assign wr_ok = io.ioctl_wr & io.ioctl_download & (io.ioctl_index == 8'd0) &
                 (state == LOAD) & ~io.ioctl_wait;
  assign start = (state == IDLE || state == DONE) & io.ioctl_download &
                 (io.ioctl_index == 8'd0);
  assign pend_slot = '{region: 2'd3, addr: {1'b0, pend_word},
                       data: {8'h00, pend_data}, be: 2'b01};

  // Region decode; offsets are relative to each region's base.
  always_comb begin
    in_range = 1'b1;
    region   = 2'd0;
    off      = io.ioctl_addr[15:0];
    if (io.ioctl_addr < SND_BASE) begin
      region = 2'd0;
    end else if (io.ioctl_addr < BG_BASE) begin
      region = 2'd1;
      off    = 16'(io.ioctl_addr - SND_BASE);
    end else if (io.ioctl_addr < SPR_BASE) begin
      region = 2'd2;
      off    = 16'(io.ioctl_addr - BG_BASE);
    end else if (io.ioctl_addr < END_ADDR) begin
      region = 2'd3;
      off    = 16'(io.ioctl_addr - SPR_BASE);
    end else begin
      in_range = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (!io.ioctl_download) state_nxt = DRAIN;
      DRAIN:      if (!pend_vld && !slot_vld) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_nxt      = slot;
    slot_vld_nxt  = slot_vld & ~accept;
    pend_vld_nxt  = pend_vld;
    pend_word_nxt = pend_word;
    pend_data_nxt = pend_data;
    flush_q_nxt   = flush_q;
    checksum_nxt  = checksum;
    overflow_nxt  = overflow;
    loaded_nxt    = loaded;
    if (start) begin
      pend_vld_nxt = 1'b0;
      flush_q_nxt  = 1'b0;
      checksum_nxt = 16'h0000;
      overflow_nxt = 1'b0;
      loaded_nxt   = 1'b0;
    end else if (wr_ok) begin
      checksum_nxt = checksum + {8'h00, io.ioctl_dout};
      if (!in_range) begin
        overflow_nxt = 1'b1;
      end else if (region != 2'd3) begin
        slot_nxt     = '{region: region, addr: off, data: {8'h00, io.ioctl_dout}, be: 2'b01};
        slot_vld_nxt = 1'b1;
      end else if (!off[0]) begin
        // Even byte displaces any older half-word, which goes out alone.
        if (pend_vld) begin
          slot_nxt     = pend_slot;
          slot_vld_nxt = 1'b1;
        end
        pend_vld_nxt  = 1'b1;
        pend_word_nxt = off[15:1];
        pend_data_nxt = io.ioctl_dout;
      end else begin
        slot_vld_nxt = 1'b1;
        if (pend_vld && pend_word == off[15:1]) begin
          slot_nxt     = '{region: 2'd3, addr: {1'b0, off[15:1]},
                           data: {io.ioctl_dout, pend_data}, be: 2'b11};
          pend_vld_nxt = 1'b0;
        end else begin
          slot_nxt = '{region: 2'd3, addr: {1'b0, off[15:1]},
                       data: {io.ioctl_dout, 8'h00}, be: 2'b10};
          // A stale pending byte from another word still has to reach the ROM.
          if (pend_vld) flush_q_nxt = 1'b1;
        end
      end
    end else if (slot_free && pend_vld && (flush_q || state == DRAIN)) begin
      slot_nxt     = pend_slot;
      slot_vld_nxt = 1'b1;
      pend_vld_nxt = 1'b0;
      flush_q_nxt  = 1'b0;
    end
    if (state == DRAIN && state_nxt == DONE) loaded_nxt = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= '0;
      slot_vld  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_word <= '0;
      pend_data <= '0;
      flush_q   <= 1'b0;
      checksum  <= 16'h0000;
      overflow  <= 1'b0;
      loaded    <= 1'b0;
      mod       <= 8'hFF;
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      slot_vld  <= slot_vld_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_word <= pend_word_nxt;
      pend_data <= pend_data_nxt;
      flush_q   <= flush_q_nxt;
      checksum  <= checksum_nxt;
      overflow  <= overflow_nxt;
      loaded    <= loaded_nxt;
      if (io.ioctl_wr && io.ioctl_download && io.ioctl_index == 8'd1) mod <= io.ioctl_dout;
    end
  end

  assign io.rom_we     = slot_vld;
  assign io.rom_region = slot.region;
  assign io.rom_addr   = slot.addr;
  assign io.rom_data   = slot.data;
  assign io.rom_be     = slot.be;
  assign io.rom_loaded = loaded;
  assign io.mod        = mod;
  assign io.checksum   = checksum;
  assign io.overflow   = overflow;

endmodule

// File: tb/tb_mylstar_rom_loader.sv
// Directed bench for mylstar_rom_loader: plain, sprite-paired, drain, stall, overflow and reset cases.
module tb_mylstar_rom_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mylstar_rom_loader_if io();
  mylstar_rom_loader dut (.clk_sys(clk), .reset(reset), .io(io));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    io.ioctl_addr = a;
    io.ioctl_dout = d;
    io.ioctl_wr   = 1'b1;
    tick();
    io.ioctl_wr   = 1'b0;
  endtask

  task automatic chk_slot(input string tag, input logic [1:0] rg, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] be);
    chk({tag, ".we"}, 32'(io.rom_we), 32'd1);
    chk({tag, ".region"}, 32'(io.rom_region), 32'(rg));
    chk({tag, ".addr"}, 32'(io.rom_addr), 32'(a));
    chk({tag, ".data"}, 32'(io.rom_data), 32'(d));
    chk({tag, ".be"}, 32'(io.rom_be), 32'(be));
  endtask

  initial begin
    io.ioctl_download = 1'b0;
    io.ioctl_index    = 8'd0;
    io.ioctl_wr       = 1'b0;
    io.ioctl_addr     = '0;
    io.ioctl_dout     = '0;
    io.rom_ready      = 1'b1;
    tick();
    tick();
    chk("rst.we", 32'(io.rom_we), 32'd0);
    chk("rst.wait", 32'(io.ioctl_wait), 32'd0);
    chk("rst.loaded", 32'(io.rom_loaded), 32'd0);
    chk("rst.mod", 32'(io.mod), 32'hFF);
    chk("rst.checksum", 32'(io.checksum), 32'd0);
    chk("rst.overflow", 32'(io.overflow), 32'd0);
    reset = 1'b0;

    // 1: CPU bytes 0..15
    io.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      wr(25'(i), 8'(i));
      chk_slot("t1", 2'd0, 16'(i), 16'(i), 2'b01);
    end
    io.ioctl_download = 1'b0;
    tick();
    tick();
    chk("t1.loaded", 32'(io.rom_loaded), 32'd1);
    chk("t1.checksum", 32'(io.checksum), 32'h0078);

    // 2/3: sprite pairing, stale-byte flush, odd-length drain
    io.ioctl_download = 1'b1;
    tick();
    chk("t2.loaded_clr", 32'(io.rom_loaded), 32'd0);
    wr(25'h1A000, 8'hAA);
    chk("t2.even_nowr", 32'(io.rom_we), 32'd0);
    wr(25'h1A001, 8'h55);
    chk_slot("t2.pair0", 2'd3, 16'h0000, 16'h55AA, 2'b11);
    wr(25'h1A002, 8'h11);
    chk("t2.even2_nowr", 32'(io.rom_we), 32'd0);
    wr(25'h1A003, 8'h22);
    chk_slot("t2.pair1", 2'd3, 16'h0001, 16'h2211, 2'b11);
    wr(25'h1A006, 8'hB0);
    chk("t2.even3_nowr", 32'(io.rom_we), 32'd0);
    wr(25'h1A008, 8'hB1);
    chk_slot("t2.flush3", 2'd3, 16'h0003, 16'h00B0, 2'b01);
    wr(25'h1A009, 8'hC1);
    chk_slot("t2.pair4", 2'd3, 16'h0004, 16'hC1B1, 2'b11);
    wr(25'h1A004, 8'h77);
    chk("t3.last_nowr", 32'(io.rom_we), 32'd0);
    io.rom_ready = 1'b0;
    io.ioctl_download = 1'b0;
    tick();
    chk("t3.drain_entry", 32'(io.rom_we), 32'd0);
    tick();
    chk_slot("t3.drain", 2'd3, 16'h0002, 16'h0077, 2'b01);
    tick();
    tick();
    chk("t3.held_we", 32'(io.rom_we), 32'd1);
    chk("t3.held_loaded", 32'(io.rom_loaded), 32'd0);
    chk("t3.held_wait", 32'(io.ioctl_wait), 32'd1);
    io.rom_ready = 1'b1;
    tick();
    chk("t3.accepted_we", 32'(io.rom_we), 32'd0);
    chk("t3.accepted_loaded", 32'(io.rom_loaded), 32'd0);
    tick();
    chk("t3.loaded", 32'(io.rom_loaded), 32'd1);
    chk("t3.checksum", 32'(io.checksum), 32'h03CB);

    // 4: back-pressure on a sound byte; a byte sent during wait is dropped
    io.ioctl_download = 1'b1;
    tick();
    io.rom_ready = 1'b0;
    wr(25'h10010, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      chk("t4.wait", 32'(io.ioctl_wait), 32'd1);
      chk_slot("t4.hold", 2'd1, 16'h0010, 16'h005A, 2'b01);
      if (i == 2) wr(25'h12000, 8'h99);
      else tick();
    end
    io.rom_ready = 1'b1;
    #1;
    chk("t4.wait_drop", 32'(io.ioctl_wait), 32'd0);
    chk("t4.we_still", 32'(io.rom_we), 32'd1);
    tick();
    chk("t4.single", 32'(io.rom_we), 32'd0);
    wr(25'h12005, 8'h33);
    chk_slot("t4.bg", 2'd2, 16'h0005, 16'h0033, 2'b01);

    // 5: out-of-range byte, then game-select byte
    wr(25'h2A000, 8'h44);
    chk("t5.oor_nowr", 32'(io.rom_we), 32'd0);
    chk("t5.overflow", 32'(io.overflow), 32'd1);
    io.ioctl_download = 1'b0;
    tick();
    tick();
    chk("t5.loaded", 32'(io.rom_loaded), 32'd1);
    chk("t5.checksum", 32'(io.checksum), 32'h00D1);
    io.ioctl_index = 8'd1;
    io.ioctl_download = 1'b1;
    tick();
    wr(25'h0, 8'h04);
    chk("t5.idx1_nowr", 32'(io.rom_we), 32'd0);
    io.ioctl_download = 1'b0;
    tick();
    chk("t5.mod", 32'(io.mod), 32'h04);
    chk("t5.loaded_kept", 32'(io.rom_loaded), 32'd1);
    chk("t5.overflow_sticky", 32'(io.overflow), 32'd1);

    // 6: reset mid-load with a full slot, then a clean reload
    io.ioctl_index = 8'd0;
    io.ioctl_download = 1'b1;
    tick();
    chk("t6.loaded_clr", 32'(io.rom_loaded), 32'd0);
    chk("t6.overflow_clr", 32'(io.overflow), 32'd0);
    chk("t6.checksum_clr", 32'(io.checksum), 32'd0);
    io.rom_ready = 1'b0;
    wr(25'h5, 8'h12);
    chk("t6.full_we", 32'(io.rom_we), 32'd1);
    chk("t6.full_wait", 32'(io.ioctl_wait), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6.rst_we", 32'(io.rom_we), 32'd0);
    chk("t6.rst_wait", 32'(io.ioctl_wait), 32'd0);
    chk("t6.rst_loaded", 32'(io.rom_loaded), 32'd0);
    chk("t6.rst_mod", 32'(io.mod), 32'hFF);
    reset = 1'b0;
    io.rom_ready = 1'b1;
    tick();
    wr(25'h0, 8'h01);
    chk_slot("t6.b0", 2'd0, 16'h0000, 16'h0001, 2'b01);
    wr(25'h1, 8'h02);
    chk_slot("t6.b1", 2'd0, 16'h0001, 16'h0002, 2'b01);
    io.ioctl_download = 1'b0;
    tick();
    tick();
    chk("t6.loaded", 32'(io.rom_loaded), 32'd1);
    chk("t6.checksum", 32'(io.checksum), 32'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
